// File: rtl/bus_mux_rr.sv
// rtl/bus_mux_rr.sv - round-robin M:1 beat multiplexer with registered output; MUX_LAST_LOCK_EN enables packet lock
module bus_mux_rr #(
    parameter int N = 16,
    parameter int M = 4,
    localparam int SELW = (($clog2(M) > 1) ? $clog2(M) : 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [M-1:0]      in_valid,
    input  logic [M*N-1:0]    in_data,
    input  logic [M-1:0]      in_last,
    output logic [M-1:0]      in_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic              out_last,
    output logic [SELW-1:0]   out_chan,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gnt;
    logic [SELW-1:0] cand;
    logic            found;
    logic            load;
    logic            xfer;

    assign load = !out_valid || out_ready;
    assign xfer = !rst && load && found;
    assign busy = out_valid || (state == LOCKED);

    // Grant search: locked channel only, or first valid channel after ptr with wrap-around
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        cand  = ptr;
        if (state == LOCKED) begin
            found = in_valid[ptr];
        end else begin
            for (int k = 1; k <= M; k++) begin
                cand = SELW'((int'(ptr) + k) % M);
                if (!found && in_valid[cand]) begin
                    found = 1'b1;
                    gnt   = cand;
                end
            end
        end
    end

    // Accept strobe: only the granted channel, only when the output register can take a beat
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Lock transitions: enter on a non-final beat, leave on the final beat of the locked channel
    always_comb begin
        state_next = state;
`ifdef MUX_LAST_LOCK_EN
        if (xfer) begin
            case (state)
                ARB:     if (!in_last[gnt]) state_next = LOCKED;
                LOCKED:  if (in_last[gnt])  state_next = ARB;
                default: state_next = ARB;
            endcase
        end
`else
        state_next = ARB;
`endif
    end

    // State, round-robin pointer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= SELW'(M - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                ptr       <= gnt;
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt)*N +: N];
                out_last  <= in_last[gnt];
                out_chan  <= gnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_rr.sv
// tb/tb_bus_mux_rr.sv - self-checking bench for bus_mux_rr against a behavioural arbiter model
module tb_bus_mux_rr;

    localparam int N = 16;
    localparam int M = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    in_valid;
    logic [M*N-1:0]  in_data;
    logic [M-1:0]    in_last;
    logic [M-1:0]    in_ready;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic            out_last;
    logic [SELW-1:0] out_chan;
    logic            out_ready;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // reference model: held beat, last grant and lock flag
    logic          mv;
    logic [N-1:0]  md;
    logic          ml;
    int            mc;
    int            mptr;
    logic          mlock;

    bus_mux_rr #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_chan(out_chan),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = 1'b0; md = '0; ml = 1'b0; mc = 0; mptr = M - 1; mlock = 1'b0;
    endtask

    function automatic int model_grant(input logic [M-1:0] v);
        if (mlock) return v[mptr] ? mptr : -1;
        for (int k = 1; k <= M; k++) begin
            if (v[(mptr + k) % M]) return (mptr + k) % M;
        end
        return -1;
    endfunction

    // one clock: drive after negedge, check ready, advance model at posedge, check outputs
    task automatic cycle(input logic [M-1:0] v, input logic [M*N-1:0] d,
                         input logic [M-1:0] l, input logic r);
        int g;
        logic [M-1:0] exp_rdy;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        g = model_grant(v);
        exp_rdy = '0;
        if ((!mv || r) && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (exp_rdy != '0) begin
            mv = 1'b1; md = d[g*N +: N]; ml = l[g]; mc = g; mptr = g;
            if (!mlock && !l[g]) mlock = 1'b1;
            else if (mlock && l[g]) mlock = 1'b0;
`ifndef MUX_LAST_LOCK_EN
            mlock = 1'b0;
`endif
        end else if (mv && r) begin
            mv = 1'b0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(mv));
        check("out_data", 64'(out_data), 64'(md));
        check("out_last", 64'(out_last), 64'(ml));
        check("out_chan", 64'(out_chan), 64'(mc));
        check("busy", 64'(busy), 64'(mv || mlock));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [M*N-1:0] dat;
        int exp_seq[5];
        int exp35[4];
        int c0;

        model_reset();
        rst = 1'b1;
        in_valid = '1; in_data = '1; in_last = '1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_chan", 64'(out_chan), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        do_reset();

        // all channels valid, full throughput, channel 0 first
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            dat = {16'h3333 + 16'(i), 16'h2222 + 16'(i), 16'h1111 + 16'(i), 16'h0000 + 16'(i)};
            cycle(4'b1111, dat, 4'b1111, 1'b1);
            check("rr_seq_chan", 64'(out_chan), 64'(exp_seq[i]));
            check("rr_seq_valid", 64'(out_valid), 64'd1);
        end

        // single channel with downstream stall
        do_reset();
        dat = {16'h0, 16'hA5A5, 16'h0, 16'h0};
        cycle(4'b0100, dat, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0100, dat, 4'b0000, 1'b0);
            check("stall_data", 64'(out_data), 64'hA5A5);
            check("stall_rdy", 64'(in_ready), 64'd0);
        end
        cycle(4'b0000, dat, 4'b0000, 1'b1);
        check("drain_valid", 64'(out_valid), 64'd0);

        // wrap-around between channels 1 and 3 starting at ptr=3
        do_reset();
        exp_seq = '{1, 3, 1, 3, 1};
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, {4{16'(i)}}, 4'b1111, 1'b1);
            check("wrap_chan", 64'(out_chan), 64'(exp_seq[i]));
        end

        // packet lock behaviour
        do_reset();
`ifdef MUX_LAST_LOCK_EN
        exp35 = '{0, 0, 0, 1};
`else
        exp35 = '{0, 1, 0, 1};
`endif
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0011, {16'h0, 16'h0, 16'hB100 + 16'(i), 16'hA000 + 16'(c0)},
                  {3'b000, (c0 == 2)}, 1'b1);
            check("lock_chan", 64'(out_chan), 64'(exp35[i]));
            if (mc == 0) c0++;
        end

        // asynchronous reset while a beat is held (and locked when enabled)
        do_reset();
        cycle(4'b0001, {4{16'h5A5A}}, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0000, '0, 4'b0000, 1'b1);
        check("arst_no_beat", 64'(out_valid), 64'd0);
        cycle(4'b1111, {4{16'h7777}}, 4'b1111, 1'b1);
        check("arst_first_chan", 64'(out_chan), 64'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15) > 4 ? 4'b1111 : 4'($urandom)),
                  1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
